// File: rtl/mul_pipe.sv
// Two-stage multiply unit: S1 holds operands feeding the array multiplier, S2 holds the product.
// Optional input skid buffer enabled by defining MUL_PIPE_SKID_EN.
module mul_pipe #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag
);

   logic             s1_valid_q, s1_valid_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic [31:0]      s1_x_q, s1_x_d;
   logic [31:0]      s1_y_q, s1_y_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_hi_sel_q, s2_hi_sel_d;
   logic [63:0]      s2_prod_q, s2_prod_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic s1_adv;
   logic s1_free;
   logic accept;
   logic s2_load;

   assign s1_adv  = s1_valid_q && (!s2_valid_q || out_ready);
   assign s1_free = !s1_valid_q || s1_adv;

`ifdef MUL_PIPE_SKID_EN
   logic             skid_valid_q, skid_valid_d;
   logic [1:0]       skid_op_q, skid_op_d;
   logic [31:0]      skid_x_q, skid_x_d;
   logic [31:0]      skid_y_q, skid_y_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

   // Readiness depends only on the skid register, cutting the ready path back to S2.
   assign in_ready = !reset && !flush && !skid_valid_q;
`else
   assign in_ready = !reset && !flush && s1_free;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      s1_tag_d   = s1_tag_q;
      if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
`ifdef MUL_PIPE_SKID_EN
      skid_valid_d = skid_valid_q;
      skid_op_d    = skid_op_q;
      skid_x_d     = skid_x_q;
      skid_y_d     = skid_y_q;
      skid_tag_d   = skid_tag_q;
      if (!flush && skid_valid_q && s1_free) begin
         s1_valid_d   = 1'b1;
         s1_op_d      = skid_op_q;
         s1_x_d       = skid_x_q;
         s1_y_d       = skid_y_q;
         s1_tag_d     = skid_tag_q;
         skid_valid_d = 1'b0;
      end else if (accept && s1_free) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_x_d     = in_src1;
         s1_y_d     = in_src2;
         s1_tag_d   = in_tag;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_op_d    = in_op;
         skid_x_d     = in_src1;
         skid_y_d     = in_src2;
         skid_tag_d   = in_tag;
      end
      if (flush) begin
         skid_valid_d = 1'b0;
      end
`else
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_x_d     = in_src1;
         s1_y_d     = in_src2;
         s1_tag_d   = in_tag;
      end
`endif
      if (flush) begin
         s1_valid_d = 1'b0;
      end
   end

   // Array multiplier: operands extended to 64 bits so one signed multiply covers both signednesses.
   logic               mul_signed;
   logic signed [63:0] mul_a;
   logic signed [63:0] mul_b;
   logic signed [63:0] mul_prod;

   assign mul_signed = (s1_op_q != 2'b10);
   assign mul_a      = {{32{mul_signed & s1_x_q[31]}}, s1_x_q};
   assign mul_b      = {{32{mul_signed & s1_y_q[31]}}, s1_y_q};
   assign mul_prod   = mul_a * mul_b;

   assign s2_load = s1_adv && !flush;

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_hi_sel_d = s2_hi_sel_q;
      s2_prod_d   = s2_prod_q;
      s2_tag_d    = s2_tag_q;
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (s2_load) begin
         s2_valid_d  = 1'b1;
         s2_hi_sel_d = (s1_op_q == 2'b01) || (s1_op_q == 2'b10);
         s2_prod_d   = mul_prod;
         s2_tag_d    = s1_tag_q;
      end else if (s2_valid_q && out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= 2'b00;
         s1_x_q      <= 32'h0;
         s1_y_q      <= 32'h0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_hi_sel_q <= 1'b0;
         s2_prod_q   <= 64'h0;
         s2_tag_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_hi_sel_q <= s2_hi_sel_d;
         s2_prod_q   <= s2_prod_d;
         s2_tag_q    <= s2_tag_d;
      end
   end

`ifdef MUL_PIPE_SKID_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         skid_valid_q <= 1'b0;
         skid_op_q    <= 2'b00;
         skid_x_q     <= 32'h0;
         skid_y_q     <= 32'h0;
         skid_tag_q   <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_op_q    <= skid_op_d;
         skid_x_q     <= skid_x_d;
         skid_y_q     <= skid_y_d;
         skid_tag_q   <= skid_tag_d;
      end
   end
`endif

   assign out_valid  = s2_valid_q;
   assign out_result = s2_hi_sel_q ? s2_prod_q[63:32] : s2_prod_q[31:0];
   assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed vectors, backpressure, flush, reset and random traffic
// checked through an expected-result queue.
module tb_mul_pipe;
   localparam int TAG_W = 5;
   localparam int EW    = 16 + TAG_W + 32;
`ifdef MUL_PIPE_SKID_EN
   localparam int BP_ACCEPTS = 3;
`else
   localparam int BP_ACCEPTS = 2;
`endif

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_src1;
   logic [31:0]      in_src2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   mul_pipe #(.TAG_W(TAG_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int               n_checks = 0;
   int               n_errors = 0;
   int               cyc = 0;
   logic [EW-1:0]    exp_q[$];
   logic [31:0]      cur_exp = 32'h0;
   logic             chk_lat = 1'b0;
   logic             hold_v = 1'b0;
   logic [31:0]      hold_res;
   logic [TAG_W-1:0] hold_tag;
   logic [EW-1:0]    mon_e;
   logic [15:0]      mon_lat;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] ps;
      logic [63:0]        pu;
      ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      pu = {32'h0, x} * {32'h0, y};
      case (op)
         2'b01:   return ps[63:32];
         2'b10:   return pu[63:32];
         default: return pu[31:0];
      endcase
   endfunction

   // scoreboard: push on input handshake, pop on output handshake
   always @(negedge clk) begin
      cyc++;
      if (reset || flush) begin
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", out_result, hold_res);
            check("hold_tag", out_tag, hold_tag);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", out_valid, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               check("result", out_result, mon_e[31:0]);
               check("tag", out_tag, mon_e[32 +: TAG_W]);
               if (chk_lat) begin
                  mon_lat = cyc[15:0] - mon_e[EW-1 -: 16];
                  check("latency", mon_lat, 16'd2);
               end
            end
         end
         hold_v   = out_valid && !out_ready;
         hold_res = out_result;
         hold_tag = out_tag;
         if (in_valid && in_ready) exp_q.push_back({cyc[15:0], in_tag, cur_exp});
      end
   end

   // driver tasks
   task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, input logic rnd);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_src1  = x;
      in_src2  = y;
      in_tag   = tag;
      cur_exp  = exp;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      if (!done) check("accept_timeout", done, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check("drain", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int          n_acc;
      bit          need_new;
      logic [31:0] rx, ry;
      logic [1:0]  rop;

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_src1   = 32'h0;
      in_src2   = 32'h0;
      in_tag    = '0;
      out_ready = 1'b1;

      // reset for two cycles
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, 32'h0);
      check("rst_out_tag", out_tag, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // back-to-back all-ones operands, latency checked
      chk_lat = 1'b1;
      send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b0);
      send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0);
      send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1'b0);
      drain();
      chk_lat = 1'b0;

      // signed corner vectors and reserved op
      send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b0);
      send(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h0000_0000, 1'b0);
      send(2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFFF, 1'b0);
      send(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd7, 32'hFFFF_FFEB, 1'b0);
      send(2'b11, 32'h0000_0003, 32'h0000_0005, 5'd8, 32'h0000_000F, 1'b0);
      drain();

      // backpressure: present tags 1,2,3 with out_ready low
      out_ready = 1'b0;
      n_acc     = 0;
      need_new  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (n_acc < 3) begin
            if (need_new) begin
               rx = $urandom();
               ry = $urandom();
               rop = 2'($urandom_range(0, 3));
               in_op = rop; in_src1 = rx; in_src2 = ry;
               in_tag = 5'(n_acc + 1);
               cur_exp = model(rop, rx, ry);
               need_new = 1'b0;
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            n_acc++;
            need_new = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check("bp_accepts", n_acc, BP_ACCEPTS);
      check("bp_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 10 && n_acc < 3; i++) begin
         if (need_new) begin
            rx = $urandom();
            ry = $urandom();
            rop = 2'($urandom_range(0, 3));
            in_op = rop; in_src1 = rx; in_src2 = ry;
            in_tag = 5'(n_acc + 1);
            cur_exp = model(rop, rx, ry);
            need_new = 1'b0;
         end
         in_valid = 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) begin
            n_acc++;
            need_new = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("bp_all_accepted", n_acc, 3);
      drain();

      // flush with two operations in flight and a new one presented
      out_ready = 1'b0;
      send(2'b00, 32'd11, 32'd13, 5'd9, model(2'b00, 32'd11, 32'd13), 1'b0);
      send(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5'd10, model(2'b01, 32'hDEAD_BEEF, 32'h1234_5678), 1'b0);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 2'b00;
      in_src1   = 32'd2;
      in_src2   = 32'd3;
      in_tag    = 5'd11;
      cur_exp   = 32'd6;
      @(negedge clk);
      check("flush_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 1'b0);
      repeat (5) @(posedge clk);
      #1;

      // reset with an operation in flight
      send(2'b10, 32'hFFFF_0000, 32'h0001_0000, 5'd12, model(2'b10, 32'hFFFF_0000, 32'h0001_0000), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_out_valid", out_valid, 1'b0);
      repeat (4) @(posedge clk);
      #1;

      // random traffic with random backpressure
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       rx = 32'h8000_0000;
            1:       rx = 32'hFFFF_FFFF;
            default: rx = $urandom();
         endcase
         ry  = $urandom();
         rop = 2'($urandom_range(0, 3));
         send(rop, rx, ry, 5'(i), model(rop, rx, ry), 1'b1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
